// File: rtl/pc_sequencer_pkg.sv
// Shared datapath definitions: Y86 instruction codes, status codes and the
// sequencer state encoding.
package pc_sequencer_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_INS = 2'd2
  } stat_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] icode;
    logic       cnd;
  } upd_ctl_t;

  function automatic logic icode_legal(input logic [3:0] ic);
    return ic <= IPOPQ;
  endfunction

  function automatic stat_e state_to_stat(input state_e s);
    case (s)
      ST_HALT: return STAT_HLT;
      ST_ERR:  return STAT_INS;
      default: return STAT_AOK;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Combinational next-PC selection from the retiring instruction; pure muxing,
// no address arithmetic.
module next_pc_sel
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  upd_ctl_t          ctl,
  input  logic [ADDR_W-1:0] val_c,
  input  logic [ADDR_W-1:0] val_p,
  input  logic [ADDR_W-1:0] val_m,
  output logic [ADDR_W-1:0] target,
  output logic              illegal
);

  always_comb begin
    target  = val_p;
    illegal = !icode_legal(ctl.icode);
    case (ctl.icode)
      ICALL:   target = val_c;
      IRET:    target = val_m;
      IJXX:    target = ctl.cnd ? val_c : val_p;
      default: target = val_p;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the RUN/HALT/ERR FSM, the PC register and the retired
// instruction counter; target selection lives in next_pc_sel.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              upd_valid_i,
  output logic              upd_ready_o,
  input  logic              stall_i,
  input  logic [3:0]        icode_i,
  input  logic              cnd_i,
  input  logic [ADDR_W-1:0] valC_i,
  input  logic [ADDR_W-1:0] valP_i,
  input  logic [ADDR_W-1:0] valM_i,
  input  logic              resume_i,
  input  logic [ADDR_W-1:0] resume_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic [1:0]        stat_o,
  output logic [CNT_W-1:0]  retired_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] target;
  logic              illegal;
  logic              accept;
  upd_ctl_t          ctl;

  assign ctl = '{icode: icode_i, cnd: cnd_i};

  next_pc_sel #(.ADDR_W(ADDR_W)) u_sel (
    .ctl     (ctl),
    .val_c   (valC_i),
    .val_p   (valP_i),
    .val_m   (valM_i),
    .target  (target),
    .illegal (illegal)
  );

  assign upd_ready_o = (state_q == ST_RUN) && !stall_i;
  assign accept      = upd_valid_i && upd_ready_o;

  // Resume is only looked at outside RUN, so it can never race an accept.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (icode_i == IHALT) state_d = ST_HALT;
            else                  pc_d    = target;
          end
        end
      end
      ST_HALT, ST_ERR: begin
        if (resume_i) begin
          pc_d    = resume_pc_i;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = (state_q == ST_RUN);
  assign stat_o     = state_to_stat(state_q);
  assign retired_o  = cnt_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 64, PC and target operand width.
REQ-002 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-003 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 upd_valid_i  input  1  update request from writeback stage.
REQ-007 upd_ready_o  output  1  update accepted this cycle when high with upd_valid_i.
REQ-008 stall_i  input  1  pipeline stall; blocks acceptance.
REQ-009 icode_i  input  4  instruction code of the retiring instruction.
REQ-010 cnd_i  input  1  branch condition for IJXX.
REQ-011 valC_i, valP_i, valM_i  input  ADDR_W each  constant target, fall-through PC, memory-read return address.
REQ-012 resume_i  input  1  restart request, effective in HALT or ERR only.
REQ-013 resume_pc_i  input  ADDR_W  PC loaded on resume.
REQ-014 pc_o  output  ADDR_W  registered current PC.
REQ-015 pc_valid_o  output  1  high when state is RUN.
REQ-016 stat_o  output  2  status: 0 AOK, 1 HLT, 2 INS.
REQ-017 retired_o  output  CNT_W  count of accepted updates.

Function
REQ-018 FSM states RUN, HALT, ERR; stat_o is AOK/HLT/INS respectively.
REQ-019 upd_ready_o SHALL be combinationally (state==RUN) && !stall_i.
REQ-020 Accept = upd_valid_i && upd_ready_o; without accept, pc_o, state and retired_o hold.
REQ-021 On accept, next pc_o: INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ -> valP_i; ICALL -> valC_i; IRET -> valM_i; IJXX -> valC_i if cnd_i else valP_i; visible one cycle after accept edge.
REQ-022 On accept with IHALT (0): pc_o holds (not zeroed), state -> HALT next cycle.
REQ-023 On accept with icode 0xC..0xF: pc_o holds, state -> ERR, retired_o not incremented.
REQ-024 retired_o increments by 1 on every accepted valid icode 0x0..0xB, including IHALT; wraps modulo 2^CNT_W.
REQ-025 In HALT or ERR, resume_i high at an edge loads pc_o=resume_pc_i, state -> RUN; retired_o unchanged.
REQ-026 In RUN, resume_i is ignored, even when coincident with upd_valid_i.
REQ-027 All targets are ADDR_W wide; no arithmetic performed; no alignment check.
REQ-028 stall_i has no effect on resume handling.

Reset
REQ-029 While rst_n_i low: pc_o=RESET_PC, state RUN, stat_o=AOK, retired_o=0, pc_valid_o=1, independent of clk_i.
REQ-030 Reset asserted mid-operation (any state) SHALL abort immediately to the values of REQ-029; first accept possible on the first rising edge after rst_n_i deasserts.

Structure
REQ-031 Icode constants (IHALT..IPOPQ), status codes and FSM state encoding SHALL live in the shared define file already used by the datapath.
REQ-032 Next-PC selection SHALL be a combinational sub-module next_pc_sel (icode, cnd, valC, valP, valM -> target, illegal flag); sequencer owns FSM, PC register and counter.

Verification
REQ-033 Reset release, ADDR_W=64, RESET_PC=0x100 -> pc_o=0x100, stat_o=0, retired_o=0, upd_ready_o=1.
REQ-034 Accept IJXX cnd=1 valC=0x40 valP=0x109, then IJXX cnd=0 valC=0x40 valP=0x49 -> pc_o 0x40 then 0x49, retired_o=2.
REQ-035 Accept ICALL valC=0x200, then IRET valM=0x10A -> pc_o 0x200 then 0x10A; upd_valid_i with stall_i=1 for 3 cycles -> pc_o, retired_o unchanged, upd_ready_o=0.
REQ-036 Accept IHALT at pc_o=0x10A -> pc_o stays 0x10A, stat_o=1, pc_valid_o=0, upd_ready_o=0; resume_i with resume_pc_i=0x300 -> pc_o=0x300, stat_o=0.
REQ-037 Accept icode 0xE -> stat_o=2, pc_o held, retired_o unchanged; further upd_valid_i ignored until resume_i.
REQ-038 CNT_W=4, 17 accepted INOPs -> retired_o=1; rst_n_i pulsed low between clock edges mid-sequence -> outputs return to reset values at once.
